// File: rtl/cd_sdpram.sv
// ============================================================================
// cd_sdpram : simple dual-port SRAM with byte enables, RDW select, clear-on-reset
// Rev 1.0
// ============================================================================
`default_nettype none

module cd_sdpram #(
    parameter int A_WIDTH    = 8,
    parameter int D_WIDTH    = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   busy,
    input  logic                   w_cen,
    input  logic [A_WIDTH-1:0]     w_addr,
    input  logic [D_WIDTH-1:0]     w_data,
    input  logic [D_WIDTH/8-1:0]   w_ben,
    input  logic                   r_cen,
    input  logic [A_WIDTH-1:0]     r_addr,
    output logic [D_WIDTH-1:0]     r_data,
    output logic                   r_valid
);

    localparam int B_NUM = D_WIDTH / 8;
    localparam int DEPTH = 2 ** A_WIDTH;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [A_WIDTH-1:0]   r_cnt;
    logic [A_WIDTH-1:0]   w_cnt_nxt;
    logic [D_WIDTH-1:0]   r_mem [DEPTH];

    logic                 w_usr_we;
    logic                 w_rd_fire;
    logic [B_NUM-1:0]     w_lane_we;
    logic [A_WIDTH-1:0]   w_wr_addr;
    logic [D_WIDTH-1:0]   w_wr_data;
    logic [D_WIDTH-1:0]   w_rd_word;

    logic                 r_s1_valid;
    logic [D_WIDTH-1:0]   r_s1_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= (CLR_ON_RST != 0) ? ST_RST : ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
            ST_CLEAR: begin
                // Counter wraps to 0 naturally after the last address
                w_cnt_nxt = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (CLR_ON_RST != 0) && (r_state != ST_IDLE);
    assign w_usr_we  = !w_cen && !busy;
    assign w_rd_fire = !r_cen && !busy;

    // The clear sequencer and the user port share one physical write port
    always_comb begin
        w_lane_we = '0;
        w_wr_addr = w_addr;
        w_wr_data = w_data;
        if (r_state == ST_CLEAR) begin
            w_lane_we = '1;
            w_wr_addr = r_cnt;
            w_wr_data = '0;
        end else if (w_usr_we) begin
            w_lane_we = ~w_ben;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < B_NUM; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rd_word = r_mem[r_addr];
        if ((RDW_MODE != 0) && w_usr_we && (w_addr == r_addr)) begin
            for (int i = 0; i < B_NUM; i++) begin
                if (!w_ben[i]) begin
                    w_rd_word[8*i +: 8] = w_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic               r_s2_valid;
            logic [D_WIDTH-1:0] r_s2_data;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign r_data  = r_s2_data;
            assign r_valid = r_s2_valid;
        end else begin : g_no_out_reg
            assign r_data  = r_s1_data;
            assign r_valid = r_s1_valid;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cd_sdpram.sv
// ============================================================================
// tb_cd_sdpram : randomized scoreboard bench for cd_sdpram (two RDW/latency variants)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cd_sdpram;

    logic        clk;
    logic        reset_n;
    logic        w_cen;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_ben;
    logic        r_cen;
    logic [3:0]  r_addr;

    logic        busy0, busy1, busy2;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        rvalid0, rvalid1, rvalid2;

    cd_sdpram #(.A_WIDTH(4), .D_WIDTH(32), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .busy(busy0),
        .w_cen(w_cen), .w_addr(w_addr), .w_data(w_data), .w_ben(w_ben),
        .r_cen(r_cen), .r_addr(r_addr), .r_data(rdata0), .r_valid(rvalid0)
    );

    cd_sdpram #(.A_WIDTH(4), .D_WIDTH(32), .RDW_MODE(1), .OUT_REG(1), .CLR_ON_RST(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .busy(busy1),
        .w_cen(w_cen), .w_addr(w_addr), .w_data(w_data), .w_ben(w_ben),
        .r_cen(r_cen), .r_addr(r_addr), .r_data(rdata1), .r_valid(rvalid1)
    );

    cd_sdpram #(.A_WIDTH(4), .D_WIDTH(32), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .busy(busy2),
        .w_cen(w_cen), .w_addr(w_addr), .w_data(w_data), .w_ben(w_ben),
        .r_cen(r_cen), .r_addr(r_addr), .r_data(rdata2), .r_valid(rvalid2)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_mem [16];
    int          m_rel = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en = 0;
    bit          exp_busy = 1;
    bit          exp_rst = 1;
    bit          done = 0;
    bit          final_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] ben);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (!ben[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // One clock of stimulus; the model applies what the coming edge should do.
    task automatic drv(input logic rstn, input logic wc, input logic [3:0] wa,
                       input logic [31:0] wd, input logic [3:0] wb,
                       input logic rc, input logic [3:0] ra);
        logic [31:0] old_w;
        logic [31:0] new_w;
        @(negedge clk);
        reset_n = rstn; w_cen = wc; w_addr = wa; w_data = wd; w_ben = wb;
        r_cen = rc; r_addr = ra;
        if (!rstn) begin
            m_rel = 0;
            for (int a = 0; a < 16; a++) m_mem[a] = 32'h0;
            q0.delete();
            q1.delete();
            exp_busy = 1;
            exp_rst  = 1;
        end else begin
            exp_rst = 0;
            if (m_rel >= 17) begin
                if (!rc) begin
                    old_w = m_mem[ra];
                    new_w = (!wc && wa == ra) ? merge(old_w, wd, wb) : old_w;
                    q0.push_back('{old_w, cyc + 1});
                    q1.push_back('{new_w, cyc + 2});
                end
                if (!wc) m_mem[wa] = merge(m_mem[wa], wd, wb);
            end
            if (m_rel < 17) m_rel++;
            exp_busy = (m_rel < 17);
        end
        chk_en = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(1'b1, 1'b1, 4'h0, 32'h0, 4'hF, 1'b1, 4'h0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic check_port(input int id, input logic v, input logic [31:0] d);
        exp_t e;
        bit   have;
        have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (id == 0) ? q0[0] : q1[0];
        if (v) begin
            if (!have) begin
                chk($sformatf("spurious_valid%0d", id), {31'b0, v}, 32'd0);
            end else begin
                if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                chk($sformatf("rdata%0d", id), d, e.d);
                chk($sformatf("latency%0d", id), cyc, e.due);
            end
        end else if (have && e.due <= cyc) begin
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk($sformatf("missing_valid%0d", id), {31'b0, v}, 32'd1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (chk_en) begin
                chk("busy0", {31'b0, busy0}, {31'b0, exp_busy});
                chk("busy1", {31'b0, busy1}, {31'b0, exp_busy});
                chk("busy_noclr", {31'b0, busy2}, 32'd0);
                if (exp_rst) begin
                    chk("rst_rdata0", rdata0, 32'd0);
                    chk("rst_rdata1", rdata1, 32'd0);
                    chk("rst_rvalid_noclr", {31'b0, rvalid2}, 32'd0);
                end
                check_port(0, rvalid0, rdata0);
                check_port(1, rvalid1, rdata1);
                if (done && !final_done) begin
                    chk("q0_drained", q0.size(), 32'd0);
                    chk("q1_drained", q1.size(), 32'd0);
                    final_done = 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; w_cen = 1'b1; w_addr = '0; w_data = '0; w_ben = '1;
        r_cen = 1'b1; r_addr = '0;

        repeat (3) drv(1'b0, 1'b1, 4'h0, 32'h0, 4'hF, 1'b1, 4'h0);
        // Reads held active through the whole clear must all be dropped
        for (int i = 0; i < 18; i++) drv(1'b1, 1'b1, 4'h0, 32'h0, 4'hF, 1'b0, 4'(i));

        for (int i = 0; i < 16; i++) drv(1'b1, 1'b0, 4'(i), 32'hFFFF_FFFF, 4'h0, 1'b1, 4'h0);
        drv(1'b1, 1'b1, 4'h0, 32'h0, 4'hF, 1'b0, 4'h2);
        drv(1'b0, 1'b1, 4'h0, 32'h0, 4'hF, 1'b1, 4'h0);
        idle(18);
        for (int i = 0; i < 16; i++) drv(1'b1, 1'b1, 4'h0, 32'h0, 4'hF, 1'b0, 4'(i));

        drv(1'b1, 1'b0, 4'h5, 32'hAABB_CCDD, 4'b0000, 1'b1, 4'h0);
        drv(1'b1, 1'b0, 4'h5, 32'h1122_3344, 4'b1010, 1'b1, 4'h0);
        drv(1'b1, 1'b1, 4'h0, 32'h0, 4'hF, 1'b0, 4'h5);

        drv(1'b1, 1'b0, 4'h3, 32'h0000_005A, 4'h0, 1'b1, 4'h0);
        drv(1'b1, 1'b0, 4'h3, 32'h0000_00A5, 4'h0, 1'b0, 4'h3);
        drv(1'b1, 1'b1, 4'h0, 32'h0, 4'hF, 1'b0, 4'h3);

        for (int i = 0; i < 8; i++) drv(1'b1, 1'b0, 4'(i), 32'(i * 3), 4'h0, 1'b1, 4'h0);
        for (int i = 0; i < 8; i++) drv(1'b1, 1'b1, 4'h0, 32'h0, 4'hF, 1'b0, 4'(i));
        idle(3);

        for (int i = 0; i < 400; i++) begin
            drv(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 32'($urandom),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
        end
        idle(3);

        // Reset at clear count 6, then hammer both ports while busy
        drv(1'b0, 1'b1, 4'h0, 32'h0, 4'hF, 1'b1, 4'h0);
        idle(7);
        drv(1'b0, 1'b1, 4'h0, 32'h0, 4'hF, 1'b1, 4'h0);
        for (int i = 0; i < 17; i++) drv(1'b1, 1'b0, 4'h9, 32'h0000_0077, 4'h0, 1'b0, 4'h9);
        drv(1'b1, 1'b1, 4'h0, 32'h0, 4'hF, 1'b0, 4'h9);
        idle(5);

        done = 1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cd_sdpram.md
# cd_sdpram

Parametrised simple dual-port SRAM: one write port and one independent read port on a single clock. Adds per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register, and a reset-triggered sequencer that zero-fills the array. It serves as the packet-buffer and register-file store for cdbus rx/tx paths that need concurrent fill and drain.

## Interface

Parameters:
- A_WIDTH, 8, address width; depth is 2**A_WIDTH words
- D_WIDTH, 8, data width; must be a multiple of 8; B_NUM = D_WIDTH/8 byte lanes
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (merged) data
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
- CLR_ON_RST, 1, 1 zero-fills the whole array after reset; 0 leaves contents undefined

Ports:
- clk  input  1  clock
- reset_n  input  1  reset; one clock, synchronous, active-low
- busy  output  1  high while the clear sequence runs; both ports are ignored while high
- w_cen  input  1  write port enable, active low
- w_addr  input  A_WIDTH  write address
- w_data  input  D_WIDTH  write data
- w_ben  input  B_NUM  byte write enables, active low; bit i covers w_data[8i+7:8i]
- r_cen  input  1  read port enable, active low
- r_addr  input  A_WIDTH  read address
- r_data  output  D_WIDTH  read data
- r_valid  output  1  one-cycle pulse marking r_data as updated for a read

## Operation

- Write: on a clk edge with w_cen low and busy low, each byte lane i with w_ben[i] low is written to ram[w_addr]; lanes with w_ben[i] high keep their contents. If all w_ben bits are high, no change.
- Read: on a clk edge with r_cen low and busy low, ram[r_addr] is sampled. r_data holds its last value when no read completes.
- Read-during-write to the same address in the same cycle:
  - RDW_MODE=0: the old word is returned.
  - RDW_MODE=1: the returned word has each enabled byte taken from w_data and the other bytes from the old word.
  - For different addresses, the two ports are fully independent.
- Clear sequencer (CLR_ON_RST=1), states RST -> CLEAR -> IDLE:
  - RST: held while reset_n is low. Counter is 0 and busy is 1.
  - CLEAR: entered on the first edge with reset_n high. Writes 0 to ram[cnt] once per cycle, cnt increments, busy is 1. After writing address 2**A_WIDTH-1, the counter wraps to 0 and the state goes to IDLE.
  - IDLE: busy is 0 and normal port operation applies.
- CLR_ON_RST=0: the state goes directly to IDLE, and busy is 0 during and after reset.
- Reset asserted mid-CLEAR: the state returns to RST and the counter goes to 0; the clear restarts from address 0 after release.
- Port requests while busy=1 are dropped. No write occurs, no r_valid is produced, and there is no queueing.

## Timing

- Reset values: r_data = 0, r_valid = 0, and busy = 1 if CLR_ON_RST else 0. With OUT_REG=1, the pipeline stage also resets to 0 and not-valid.
- Clear duration: busy falls on the 2**A_WIDTH-th edge after the first edge with reset_n high. The first usable cycle is the one in which busy is sampled low.
- Read latency:
  - OUT_REG=0: request sampled at edge N, r_data/r_valid updated at edge N+1.
  - OUT_REG=1: updated at edge N+2.
- Throughput is one read and one write per cycle. Back-to-back reads produce consecutive r_valid pulses in request order.
- Write then read of the same address at a later edge always returns the written data.
- A read issued in the last CLEAR cycle (busy still 1) is dropped.
- A read in flight when reset_n asserts is discarded; r_valid is 0 from the reset edge onward.

## Test plan

- Reset clear: A_WIDTH=4, CLR_ON_RST=1, pre-write 0xFF everywhere, pulse reset_n. Required: busy stays high for exactly 16 cycles after release, then reads of all 16 addresses return 0x00.
- Byte enables: D_WIDTH=32, write 0xAABBCCDD with w_ben=0000, then 0x11223344 with w_ben=1010 to addr 5. Required: a read of addr 5 returns 0xAA22CC44.
- Read-during-write: addr 3 holds 0x5A; in the same cycle write 0xA5 and read addr 3. Required: RDW_MODE=0 returns 0x5A, RDW_MODE=1 returns 0xA5, and a subsequent read returns 0xA5 in both modes.
- Latency/throughput: OUT_REG=1, reads of addr 0..7 on consecutive cycles holding data = addr*3. Required: r_valid rises 2 cycles after the first request, stays high for 8 cycles, and r_data is 0,3,...,21 in order.
- Mid-clear reset and busy gating: assert reset_n at clear count 6 and issue a write/read while busy. Required: the clear restarts at 0 and lasts a full 2**A_WIDTH cycles, no r_valid occurs while busy, and the dropped write leaves 0 at its address.
